button_array: RTL and testbench

BUTTON_ARRAY -- requirements
Module: button_array

---
 rtl/button_pkg.sv | 17 +
 rtl/button_channel.sv | 202 ++++++++++++++++++++
 rtl/button_array.sv | 59 +++++
 tb/tb_button_array.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button debouncer array.
//   btn_state_t : per-channel debounce FSM state encoding
//   cnt_w()     : width needed for a counter that must hold max_cnt
package button_pkg;

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } btn_state_t;

   function automatic int cnt_w(input int max_cnt);
      return $clog2(max_cnt) + 1;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button channel: 2-flop synchronizer, debounce FSM, edge
// pulses, long-press timer and (optionally) auto-repeat timer.
// Optional feature: BUTTON_ARRAY_REPEAT_EN enables the auto-repeat timer;
// without it repeat_pulse is tied low and no repeat counter exists.
//
// Ports
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   noisy        : raw asynchronous button input
//   debounced    : filtered level
//   p_edge       : one-clock pulse, accepted 0->1
//   n_edge       : one-clock pulse, accepted 1->0
//   any_edge     : p_edge | n_edge
//   long_press   : one-clock pulse LONG_CYCLES clocks after p_edge
//   repeat_pulse : periodic pulse after long_press while still held
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_LOW       | accepted level 0, input stable low
// ST_WAIT_HIGH | accepted level 0, input high, timing the stable window
// ST_HIGH      | accepted level 1, input stable high
// ST_WAIT_LOW  | accepted level 1, input low, timing the stable window
module button_channel
   import button_pkg::*;
#(
   parameter int DB_CYCLES     = 2_000_000,
   parameter int LONG_CYCLES   = 100_000_000
`ifdef BUTTON_ARRAY_REPEAT_EN
 , parameter int REPEAT_CYCLES = 20_000_000
`endif
) (
   input  logic clk,
   input  logic reset_n,
   input  logic noisy,
   output logic debounced,
   output logic p_edge,
   output logic n_edge,
   output logic any_edge,
   output logic long_press,
   output logic repeat_pulse
);

   localparam int DB_W   = cnt_w(DB_CYCLES);
   localparam int HOLD_W = cnt_w(LONG_CYCLES);

   // The first stable clock is the one that leaves the idle state, so the
   // window counter starts two short of DB_CYCLES and ends at zero.
   localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DB_CYCLES - 2);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LONG_CYCLES - 1);

   logic sync_q1;
   logic synced;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= 1'b0;
         synced  <= 1'b0;
      end else begin
         sync_q1 <= noisy;
         synced  <= sync_q1;
      end
   end

   btn_state_t       state;
   btn_state_t       state_nxt;
   logic [DB_W-1:0]  db_cnt;
   logic [DB_W-1:0]  db_cnt_nxt;
   logic             rise;
   logic             fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_LOW;
         db_cnt <= '0;
      end else begin
         state  <= state_nxt;
         db_cnt <= db_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      db_cnt_nxt = db_cnt;
      rise       = 1'b0;
      fall       = 1'b0;
      case (state)
         ST_LOW: begin
            if (synced) begin
               state_nxt  = ST_WAIT_HIGH;
               db_cnt_nxt = DB_LOAD;
            end
         end
         ST_WAIT_HIGH: begin
            if (!synced) begin
               state_nxt  = ST_LOW;
               db_cnt_nxt = '0;
            end else if (db_cnt == '0) begin
               state_nxt = ST_HIGH;
               rise      = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt - DB_W'(1);
            end
         end
         ST_HIGH: begin
            if (!synced) begin
               state_nxt  = ST_WAIT_LOW;
               db_cnt_nxt = DB_LOAD;
            end
         end
         ST_WAIT_LOW: begin
            if (synced) begin
               state_nxt  = ST_HIGH;
               db_cnt_nxt = '0;
            end else if (db_cnt == '0) begin
               state_nxt = ST_LOW;
               fall      = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt - DB_W'(1);
            end
         end
         default: begin
            state_nxt  = ST_LOW;
            db_cnt_nxt = '0;
         end
      endcase
   end

   assign debounced = (state == ST_HIGH) || (state == ST_WAIT_LOW);

   // Hold timer: armed by the accepted press, disarmed by the accepted
   // release or after firing once (it then rests at zero). Bounces inside
   // ST_WAIT_LOW do not touch it.
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_armed;
   logic              lp_fire;

   assign lp_fire = hold_armed && !rise && !fall && (hold_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_edge     <= 1'b0;
         n_edge     <= 1'b0;
         any_edge   <= 1'b0;
         long_press <= 1'b0;
         hold_cnt   <= '0;
         hold_armed <= 1'b0;
      end else begin
         p_edge     <= rise;
         n_edge     <= fall;
         any_edge   <= rise | fall;
         long_press <= lp_fire;
         if (rise) begin
            hold_cnt   <= HOLD_LOAD;
            hold_armed <= 1'b1;
         end else if (fall) begin
            hold_cnt   <= '0;
            hold_armed <= 1'b0;
         end else if (hold_armed) begin
            if (hold_cnt == '0) begin
               hold_armed <= 1'b0;
            end else begin
               hold_cnt <= hold_cnt - HOLD_W'(1);
            end
         end
      end
   end

`ifdef BUTTON_ARRAY_REPEAT_EN
   localparam int                REP_W    = cnt_w(REPEAT_CYCLES);
   localparam logic [REP_W-1:0]  REP_LOAD = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_active;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         repeat_pulse <= 1'b0;
         rep_cnt      <= '0;
         rep_active   <= 1'b0;
      end else begin
         repeat_pulse <= 1'b0;
         if (fall) begin
            rep_cnt    <= '0;
            rep_active <= 1'b0;
         end else if (lp_fire) begin
            rep_cnt    <= REP_LOAD;
            rep_active <= 1'b1;
         end else if (rep_active) begin
            if (rep_cnt == '0) begin
               repeat_pulse <= 1'b1;
               rep_cnt      <= REP_LOAD;
            end else begin
               rep_cnt <= rep_cnt - REP_W'(1);
            end
         end
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_array.sv
// Array of N_CH independent debounced button channels.
// Optional feature: BUTTON_ARRAY_REPEAT_EN enables per-channel auto-repeat;
// without it repeat_pulse is constant 0.
//
// Ports (all vectors N_CH wide, one bit per channel)
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   noisy        : raw asynchronous button inputs
//   debounced    : filtered levels
//   p_edge       : accepted 0->1 pulses
//   n_edge       : accepted 1->0 pulses
//   any_edge     : p_edge | n_edge
//   long_press   : long-hold pulses
//   repeat_pulse : auto-repeat pulses
module button_array
   import button_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int DB_CYCLES     = 2_000_000,
   parameter int LONG_CYCLES   = 100_000_000,
   parameter int REPEAT_CYCLES = 20_000_000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] noisy,
   output logic [N_CH-1:0] debounced,
   output logic [N_CH-1:0] p_edge,
   output logic [N_CH-1:0] n_edge,
   output logic [N_CH-1:0] any_edge,
   output logic [N_CH-1:0] long_press,
   output logic [N_CH-1:0] repeat_pulse
);

   if (N_CH < 1 || N_CH > 32 || DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES ||
       REPEAT_CYCLES < 2) begin : g_bad_params
      $error("button_array: illegal parameter set");
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      button_channel #(
         .DB_CYCLES     (DB_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES)
`ifdef BUTTON_ARRAY_REPEAT_EN
       , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
      ) u_ch (
         .clk          (clk),
         .reset_n      (reset_n),
         .noisy        (noisy[gi]),
         .debounced    (debounced[gi]),
         .p_edge       (p_edge[gi]),
         .n_edge       (n_edge[gi]),
         .any_edge     (any_edge[gi]),
         .long_press   (long_press[gi]),
         .repeat_pulse (repeat_pulse[gi])
      );
   end

endmodule

// File: tb/tb_button_array.sv
// Directed bench for button_array (N_CH=4, DB_CYCLES=8, LONG_CYCLES=32,
// REPEAT_CYCLES=8). Stimulus pushes the expected pulse cycles into a
// scoreboard; a negedge monitor pops and compares whenever any pulse appears.
module tb_button_array;

   localparam int N_CH = 4;
   localparam int DB   = 8;
   localparam int LONG = 32;
   localparam int REP  = 8;

   logic            clk     = 1'b0;
   logic            reset_n = 1'b0;
   logic [N_CH-1:0] noisy   = '0;
   logic [N_CH-1:0] debounced;
   logic [N_CH-1:0] p_edge;
   logic [N_CH-1:0] n_edge;
   logic [N_CH-1:0] any_edge;
   logic [N_CH-1:0] long_press;
   logic [N_CH-1:0] repeat_pulse;

   button_array #(
      .N_CH          (N_CH),
      .DB_CYCLES     (DB),
      .LONG_CYCLES   (LONG),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .noisy        (noisy),
      .debounced    (debounced),
      .p_edge       (p_edge),
      .n_edge       (n_edge),
      .any_edge     (any_edge),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int         cyc;
      logic [3:0] p;
      logic [3:0] n;
      logic [3:0] lp;
      logic [3:0] rp;
      logic [3:0] deb;
   } exp_t;

   exp_t sb[$];

   task automatic push(input int c, input logic [3:0] p, input logic [3:0] n,
                       input logic [3:0] lp, input logic [3:0] rp,
                       input logic [3:0] deb);
      exp_t e;
      e.cyc = c; e.p = p; e.n = n; e.lp = lp; e.rp = rp; e.deb = deb;
      sb.push_back(e);
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_debounced"}, debounced, 4'b0);
      chk({tag, "_p_edge"}, p_edge, 4'b0);
      chk({tag, "_n_edge"}, n_edge, 4'b0);
      chk({tag, "_any_edge"}, any_edge, 4'b0);
      chk({tag, "_long_press"}, long_press, 4'b0);
      chk({tag, "_repeat"}, repeat_pulse, 4'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && reset_n) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_pulse: nothing seen at cycle %0d, expected p=%b n=%b lp=%b rp=%b",
                     e.cyc, e.p, e.n, e.lp, e.rp);
         end
         if (|{p_edge, n_edge, any_edge, long_press, repeat_pulse}) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pulse: cycle %0d got p=%b n=%b any=%b lp=%b rp=%b, expected none",
                        cyc, p_edge, n_edge, any_edge, long_press, repeat_pulse);
            end else begin
               e = sb.pop_front();
               tests++;
               if ({p_edge, n_edge, any_edge, long_press, repeat_pulse, debounced} !==
                   {e.p, e.n, e.p | e.n, e.lp, e.rp, e.deb}) begin
                  fails++;
                  $display("FAIL pulse_cmp: cycle %0d got p=%b n=%b any=%b lp=%b rp=%b deb=%b expected p=%b n=%b any=%b lp=%b rp=%b deb=%b",
                           cyc, p_edge, n_edge, any_edge, long_press, repeat_pulse, debounced,
                           e.p, e.n, e.p | e.n, e.lp, e.rp, e.deb);
               end
            end
         end
      end
   end

   initial begin
      int t0;
      int r;

      // reset state
      #1;
      check_zero("reset_t0");
      tick(3);
      check_zero("reset_held");
      reset_n = 1'b1;
      mon_en  = 1'b1;
      tick(5);

      // clean step on channel 0: press, long press, release
      t0 = cyc;
      noisy[0] = 1'b1;
      push(t0 + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      push(t0 + 42, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
`ifdef BUTTON_ARRAY_REPEAT_EN
      push(t0 + 50, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
      push(t0 + 55, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tick(9);
      chk("deb_before_window", debounced, 4'b0000);
      tick(1);
      chk("deb_after_window", debounced, 4'b0001);
      tick(35);
      noisy[0] = 1'b0;
      tick(15);
      chk("deb_after_release", debounced, 4'b0000);

      // channel 1 bursts: ends high, later ends low; release cancels long press
      t0 = cyc;
      push(t0 + 22, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
      push(t0 + 52, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         noisy[1] = ~noisy[1];
         tick(3);
      end
      tick(15);
      for (int i = 0; i < 5; i++) begin
         noisy[1] = ~noisy[1];
         tick(3);
      end
      tick(20);
      chk("burst_final_level", debounced, 4'b0000);

      // channel 2: bounce during hold, long press, auto-repeat, release
      t0 = cyc;
      noisy[2] = 1'b1;
      push(t0 + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      push(t0 + 42, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
`ifdef BUTTON_ARRAY_REPEAT_EN
      for (int k = 50; k <= 82; k += 8)
         push(t0 + k, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
      push(t0 + 89, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      tick(20);
      noisy[2] = 1'b0;
      tick(3);
      noisy[2] = 1'b1;
      tick(3);
      chk("deb_through_bounce", debounced, 4'b0100);
      tick(53);
      noisy[2] = 1'b0;
      tick(20);

      // simultaneous steps on channels 0 and 3
      t0 = cyc;
      noisy = 4'b1001;
      push(t0 + 10, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
      push(t0 + 30, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
      tick(20);
      noisy = 4'b0000;
      tick(20);

      // reset during WAIT_HIGH, then during hold, with noisy kept high
      noisy[0] = 1'b1;
      tick(5);
      reset_n = 1'b0;
      #1;
      check_zero("rst_wait_high");
      tick(2);
      reset_n = 1'b1;
      r = cyc;
      push(r + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      tick(20);
      chk("deb_before_hold_rst", debounced, 4'b0001);
      reset_n = 1'b0;
      #1;
      check_zero("rst_hold");
      tick(2);
      reset_n = 1'b1;
      r = cyc;
      push(r + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      push(r + 25, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tick(15);
      noisy[0] = 1'b0;
      tick(40);

      mon_en = 1'b0;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_pulse: nothing seen at cycle %0d, expected p=%b n=%b lp=%b rp=%b",
                  e.cyc, e.p, e.n, e.lp, e.rp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
